// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states, operation kinds.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_MADD  = 3'd6;
  localparam logic [2:0] MDU_MADDU = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_t;

  typedef enum logic [1:0] {
    KIND_MUL  = 2'd0,
    KIND_DIV  = 2'd1,
    KIND_MADD = 2'd2,
    KIND_NOP  = 2'd3
  } mdu_kind_t;

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add multiply (mode=0) or restoring divide step (mode=1).
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode,
  input  logic [WIDTH:0]   upper,
  input  logic [WIDTH-1:0] lower,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH:0]   upper_next,
  output logic [WIDTH-1:0] lower_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    sum     = upper + {1'b0, (lower[0] ? operand : {WIDTH{1'b0}})};
    shifted = {upper[WIDTH-1:0], lower[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, operand};
    if (mode) begin
      // Borrow out of the trial subtract means the divisor did not fit: restore.
      if (trial[WIDTH+1]) begin
        upper_next = shifted;
        lower_next = {lower[WIDTH-2:0], 1'b0};
      end else begin
        upper_next = trial[WIDTH:0];
        lower_next = {lower[WIDTH-2:0], 1'b1};
      end
    end else begin
      upper_next = {1'b0, sum[WIDTH:1]};
      lower_next = {sum[0], lower[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO, one step per clock.
// Define MDU_MADD_EN to enable MADD/MADDU accumulate into {hi,lo} (one extra FIX cycle).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mdu_state_t state, state_next;
  mdu_kind_t  kind, kind_new;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   upper, upper_next;
  logic [WIDTH-1:0] lower, lower_next, opnd;
  logic             sign_q, sign_r, bz;
  logic             is_signed, is_move, a_neg, b_neg, last_iter;
  logic [WIDTH-1:0] mag_a, mag_b, quo_fix, rem_fix;
  logic signed [2*WIDTH-1:0] prod_fix;
`ifdef MDU_MADD_EN
  logic                      fix_phase;
  logic signed [2*WIDTH-1:0] prod_r;
`endif

  function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic neg, input logic [2*WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  always_comb begin
    is_signed = (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD);
    is_move   = (op == MDU_MTHI) || (op == MDU_MTLO);
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    mag_a     = cond_neg(a_neg, a);
    mag_b     = cond_neg(b_neg, b);
    case (op)
      MDU_MULT, MDU_MULTU: kind_new = KIND_MUL;
      MDU_DIV, MDU_DIVU:   kind_new = KIND_DIV;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU: kind_new = KIND_MADD;
`else
      MDU_MADD, MDU_MADDU: kind_new = KIND_NOP;
`endif
      default:             kind_new = KIND_NOP;
    endcase
  end

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .mode       (kind == KIND_DIV),
    .upper      (upper),
    .lower      (lower),
    .operand    (opnd),
    .upper_next (upper_next),
    .lower_next (lower_next)
  );

  // Sign correction; a zero divisor forces an all-ones quotient while the
  // remainder path already reproduces the original dividend.
  always_comb begin
    last_iter = (cnt == CNT_W'(WIDTH - 1));
    prod_fix  = cond_neg2(sign_q, {upper[WIDTH-1:0], lower});
    quo_fix   = bz ? {WIDTH{1'b1}} : cond_neg(sign_q, lower);
    rem_fix   = cond_neg(sign_r, upper[WIDTH-1:0]);
  end

  always_comb begin
    state_next = state;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: if (start && !is_move) state_next = (kind_new == KIND_NOP) ? ST_FIX : ST_CALC;
      ST_CALC: if (last_iter) state_next = ST_FIX;
      ST_FIX: begin
`ifdef MDU_MADD_EN
        if (!(kind == KIND_MADD && !fix_phase)) state_next = ST_IDLE;
`else
        state_next = ST_IDLE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture and iteration stage
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      kind   <= kind_new;
      bz     <= (b == '0);
      sign_q <= a_neg ^ b_neg;
      sign_r <= a_neg;
      upper  <= '0;
      if (kind_new == KIND_DIV) begin
        lower <= mag_a;
        opnd  <= mag_b;
      end else begin
        lower <= mag_b;
        opnd  <= mag_a;
      end
    end else if (state == ST_CALC) begin
      upper <= upper_next;
      lower <= lower_next;
    end
`ifdef MDU_MADD_EN
    if (state == ST_FIX) prod_r <= prod_fix;
`endif
  end

  // Result write-back stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
`ifdef MDU_MADD_EN
      fix_phase   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          cnt <= '0;
          if (op == MDU_MTHI) begin
            hi   <= a;
            done <= 1'b1;
          end else if (op == MDU_MTLO) begin
            lo   <= a;
            done <= 1'b1;
          end else begin
            div_by_zero <= 1'b0;
          end
        end
        ST_CALC: cnt <= cnt + CNT_W'(1);
        ST_FIX: begin
`ifdef MDU_MADD_EN
          if (kind == KIND_MADD) begin
            if (!fix_phase) begin
              fix_phase <= 1'b1;
            end else begin
              fix_phase <= 1'b0;
              {hi, lo}  <= {hi, lo} + prod_r;
              done      <= 1'b1;
            end
          end else
`endif
          begin
            done <= 1'b1;
            if (kind == KIND_MUL) begin
              {hi, lo} <= prod_fix;
            end else if (kind == KIND_DIV) begin
              hi          <= rem_fix;
              lo          <= quo_fix;
              div_by_zero <= bz;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32); MADD vectors when MDU_MADD_EN is defined.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait (bounded) for done; lat counts edges after the accepting edge.
  task automatic do_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    step();
    start    = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h0BAD_F00D;
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      step();
      lat++;
    end
    if (!done) check("timeout", 64'd0, 64'd1);
  endtask

  int lat, bc, seen;

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi",   64'(hi), 64'd0);
    check("rst_lo",   64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz",  64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, lat, bc);
    check("mult_lat",  64'(lat), 64'd33);
    check("mult_busy", 64'(bc), 64'd33);
    check("mult_hi",   64'(hi), 64'hFFFF_FFFF);
    check("mult_lo",   64'(lo), 64'hFFFF_FFEB);
    step();
    check("mult_done_pulse", 64'(done), 64'd0);
    check("mult_hold_lo",    64'(lo), 64'hFFFF_FFEB);

    do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(lo), 64'h0000_0001);

    do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc);
    check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

    do_op(MDU_DIVU, 32'd7, 32'd2, lat, bc);
    check("divu_lo", 64'(lo), 64'd3);
    check("divu_hi", 64'(hi), 64'd1);

    do_op(MDU_DIV, 32'h1234_5678, 32'd0, lat, bc);
    check("dbz_lat",  64'(lat), 64'd33);
    check("dbz_hi",   64'(hi), 64'h1234_5678);
    check("dbz_lo",   64'(lo), 64'hFFFF_FFFF);
    check("dbz_flag", 64'(div_by_zero), 64'd1);

    do_op(MDU_MTLO, 32'h0000_00A5, 32'd0, lat, bc);
    check("mtlo_lat",  64'(lat), 64'd0);
    check("mtlo_busy", 64'(busy | (bc != 0)), 64'd0);
    check("mtlo_lo",   64'(lo), 64'hA5);
    check("mtlo_hi",   64'(hi), 64'h1234_5678);
    check("mtlo_flag", 64'(div_by_zero), 64'd1);
    step();
    check("mtlo_done_pulse", 64'(done), 64'd0);

    do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    check("intmin_lo",   64'(lo), 64'h8000_0000);
    check("intmin_hi",   64'(hi), 64'd0);
    check("intmin_flag", 64'(div_by_zero), 64'd0);

    do_op(MDU_DIV, 32'hFFFF_FFFB, 32'd0, lat, bc);
    check("dbz_neg_hi", 64'(hi), 64'hFFFF_FFFB);
    check("dbz_neg_lo", 64'(lo), 64'hFFFF_FFFF);

    // MULTU 5*5 with a DIVU start while busy that must be dropped.
    @(negedge clk);
    start = 1'b1; op = MDU_MULTU; a = 32'd5; b = 32'd5;
    step();
    start = 1'b0;
    repeat (9) step();
    @(negedge clk);
    start = 1'b1; op = MDU_DIVU; a = 32'd100; b = 32'd3;
    step();
    start = 1'b0;
    lat = 10;
    while (!done && lat < 100) begin
      step();
      lat++;
    end
    check("ign_lat", 64'(lat), 64'd33);
    check("ign_hi",  64'(hi), 64'd0);
    check("ign_lo",  64'(lo), 64'd25);
    step();
    check("ign_no_second", 64'(busy | done), 64'd0);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = MDU_DIV; a = 32'd1000; b = 32'd7;
    step();
    start = 1'b0;
    repeat (14) step();
    check("midrst_busy_before", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_lo",   64'(lo), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      step();
      if (done || busy) seen++;
    end
    check("midrst_no_done", 64'(seen), 64'd0);

    do_op(MDU_MTHI, 32'h0000_0077, 32'd0, lat, bc);
    check("mthi_hi", 64'(hi), 64'h77);
    check("mthi_lo", 64'(lo), 64'd0);

`ifdef MDU_MADD_EN
    do_op(MDU_MTLO, 32'd5, 32'd0, lat, bc);
    do_op(MDU_MTHI, 32'd0, 32'd0, lat, bc);
    do_op(MDU_MADD, 32'd2, 32'd3, lat, bc);
    check("madd_lat", 64'(lat), 64'd34);
    check("madd_hi",  64'(hi), 64'd0);
    check("madd_lo",  64'(lo), 64'h0B);
    do_op(MDU_MTLO, 32'd1, 32'd0, lat, bc);
    do_op(MDU_MTHI, 32'd0, 32'd0, lat, bc);
    do_op(MDU_MADDU, 32'hFFFF_FFFF, 32'd2, lat, bc);
    check("maddu_hi", 64'(hi), 64'd1);
    check("maddu_lo", 64'(lo), 64'hFFFF_FFFF);
`else
    do_op(MDU_MADD, 32'd2, 32'd3, lat, bc);
    check("nop_lat", 64'(lat), 64'd1);
    check("nop_hi",  64'(hi), 64'h77);
    check("nop_lo",  64'(lo), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
